// File: rtl/serial_to_parallel.sv
// serial_to_parallel: packs a serial bit stream into 2-bit (QPSK) or 4-bit
// (16QAM) symbols. Completed symbols go through a small FIFO to a
// valid/ready symbol port.
// Optional feature: define S2P_SYMBOL_COUNT_EN to build a counter of popped
// symbols on sym_count. Without the macro, sym_count is tied to 0.
module serial_to_parallel #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mod_type,
  input  logic                          sync_clr,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic                          bit_ready,
  output logic [3:0]                    sym_data,
  output logic                          sym_mod_type,
  output logic                          sym_valid,
  input  logic                          sym_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              sym_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic {IDLE, ACC} state_e;

  typedef struct packed {
    logic       mod;
    logic [3:0] data;
  } sym_t;

  state_e           state_q;
  logic [1:0]       cnt_q;
  logic [2:0]       shift_q;
  logic             mod_q;

  sym_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;

  logic             fifo_full_c;
  logic             bit_acc_c;
  logic             cur_mod_c;
  logic             last_c;
  logic             push_c;
  logic             pop_c;
  sym_t             push_sym_c;

  // Handshake and symbol-completion decode from registered state
  always_comb begin
    fifo_full_c = (level_q == LVL_W'(FIFO_DEPTH));
    bit_ready   = !fifo_full_c && !sync_clr;
    bit_acc_c   = bit_valid && bit_ready;
    cur_mod_c   = (state_q == IDLE) ? mod_type : mod_q;
    last_c      = cur_mod_c ? (cnt_q == 2'd3) : (cnt_q == 2'd1);
    push_c      = bit_acc_c && last_c;
    pop_c       = sym_valid && sym_ready && !sync_clr;
    push_sym_c.mod  = cur_mod_c;
    push_sym_c.data = cur_mod_c ? {shift_q, bit_in} : {2'b00, shift_q[0], bit_in};
  end

  // FIFO head drives the symbol port directly
  always_comb begin
    sym_valid    = (level_q != '0);
    sym_data     = mem_q[rd_ptr_q].data;
    sym_mod_type = mem_q[rd_ptr_q].mod;
    fifo_level   = level_q;
  end

  // Bit-counter FSM; shift register is cleared between symbols so the
  // first bit always starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      shift_q <= 3'd0;
      mod_q   <= 1'b0;
    end else if (sync_clr) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      shift_q <= 3'd0;
    end else if (bit_acc_c) begin
      if (state_q == IDLE) begin
        mod_q <= mod_type;
      end
      if (last_c) begin
        state_q <= IDLE;
        cnt_q   <= 2'd0;
        shift_q <= 3'd0;
      end else begin
        state_q <= ACC;
        cnt_q   <= cnt_q + 2'd1;
        shift_q <= {shift_q[1:0], bit_in};
      end
    end
  end

  // Symbol storage; written on the last bit of each symbol
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= push_sym_c;
    end
  end

  // FIFO pointers and occupancy; sync clear flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (sync_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef S2P_SYMBOL_COUNT_EN
  logic [CNT_W-1:0] sym_cnt_q;

  // Popped-symbol counter; only rst_n clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt_q <= '0;
    end else if (pop_c) begin
      sym_cnt_q <= sym_cnt_q + CNT_W'(1);
    end
  end

  assign sym_count = sym_cnt_q;
`else
  assign sym_count = '0;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Randomized self-checking bench for serial_to_parallel with a queue-based
// reference model, plus directed cases with literal expectations.
module tb_serial_to_parallel;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mod_type = 1'b0;
  logic          sync_clr = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic [3:0]    sym_data;
  logic          sym_mod_type;
  logic          sym_valid;
  logic          sym_ready = 1'b0;
  logic [2:0]    fifo_level;
  logic [CW-1:0] sym_count;

  serial_to_parallel #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mod_type(mod_type), .sync_clr(sync_clr),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_data(sym_data), .sym_mod_type(sym_mod_type), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .fifo_level(fifo_level), .sym_count(sym_count)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;
  bit          chk_en = 1'b0;

  // Reference model: queued symbols {mod,data}, partial symbol as a number
  logic [4:0]  q[$];
  int          pcnt = 0;
  int          pval = 0;
  logic        pmod = 1'b0;
  int unsigned pops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    pcnt = 0;
    pval = 0;
    pops = 0;
  endtask

  task automatic model_update(input logic v, b, m, c, r);
    bit rdy_m;
    if (c) begin
      q.delete();
      pcnt = 0;
      pval = 0;
    end else begin
      rdy_m = (q.size() < DEPTH);
      if (q.size() > 0 && r) begin
        void'(q.pop_front());
        pops++;
      end
      if (v && rdy_m) begin
        if (pcnt == 0) pmod = m;
        pval = pval * 2 + int'(b);
        pcnt++;
        if (pcnt == (pmod ? 4 : 2)) begin
          q.push_back({pmod, 4'(pval)});
          pcnt = 0;
          pval = 0;
        end
      end
    end
  endtask

  // One clock of stimulus; model advances with the DUT at the edge
  task automatic step(input logic v, b, m, c, r);
    bit_valid = v;
    bit_in    = b;
    mod_type  = m;
    sync_clr  = c;
    sym_ready = r;
    @(posedge clk);
    #1;
    model_update(v, b, m, c, r);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bit_ready", 32'(bit_ready), 32'((q.size() < DEPTH) && !sync_clr));
      chk("sym_valid", 32'(sym_valid), 32'(q.size() != 0));
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      if (q.size() != 0) begin
        chk("sym_data", 32'(sym_data), 32'(q[0][3:0]));
        chk("sym_mod_type", 32'(sym_mod_type), 32'(q[0][4]));
      end
`ifdef S2P_SYMBOL_COUNT_EN
      chk("sym_count", sym_count, pops);
`else
      chk("sym_count", sym_count, 32'd0);
`endif
    end
  end

  initial begin
    logic [3:0] kk;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_sym_valid", 32'(sym_valid), 32'd0);
    chk("rst_bit_ready", 32'(bit_ready), 32'd1);
    chk("rst_sym_data", 32'(sym_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // QPSK 1,0
    step(1, 1, 0, 0, 1);
    chk("qpsk_not_yet_valid", 32'(sym_valid), 32'd0);
    step(1, 0, 0, 0, 1);
    chk("qpsk_valid", 32'(sym_valid), 32'd1);
    chk("qpsk_data", 32'(sym_data), 32'b0010);
    chk("qpsk_mod", 32'(sym_mod_type), 32'd0);

    // 16QAM 1,0,1,1 (first step pops the QPSK symbol)
    step(1, 1, 1, 0, 1);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("qam_data", 32'(sym_data), 32'b1011);
    chk("qam_mod", 32'(sym_mod_type), 32'd1);

    // mod_type drops after first bit: still a 4-bit symbol, next is QPSK
    step(1, 1, 1, 0, 1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("toggle_data", 32'(sym_data), 32'b1101);
    chk("toggle_mod", 32'(sym_mod_type), 32'd1);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    chk("next_qpsk_data", 32'(sym_data), 32'b0011);
    chk("next_qpsk_mod", 32'(sym_mod_type), 32'd0);
    chk("next_qpsk_level", 32'(fifo_level), 32'd1);

    // Fill the FIFO with 10 QPSK symbols offered, sym_ready low
    repeat (4) step(0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      kk = 4'(k);
      step(1, kk[1], 0, 0, 0);
      step(1, kk[0], 0, 0, 0);
    end
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_bit_ready", 32'(bit_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("drain_order", 32'(sym_data), 32'(k));
      step(0, 0, 0, 0, 1);
    end
    chk("drained_valid", 32'(sym_valid), 32'd0);

    // Simultaneous push and pop keeps the level
    for (int k = 0; k < 7; k++) step(1, 1'(k & 1), 0, 0, 0);
    chk("pre_pp_level", 32'(fifo_level), 32'd3);
    step(1, 0, 0, 0, 1);
    chk("pp_level", 32'(fifo_level), 32'd3);
    chk("pp_head", 32'(sym_data), 32'b0001);

    // sync_clr mid-symbol with two symbols queued
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 11; k++) step(1, 1'(k % 3 == 0), 1, 0, 0);
    chk("pre_clr_level", 32'(fifo_level), 32'd2);
    step(1, 1, 1, 1, 1);
    chk("clr_level", 32'(fifo_level), 32'd0);
    chk("clr_valid", 32'(sym_valid), 32'd0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("fresh_data", 32'(sym_data), 32'b0110);
    chk("fresh_level", 32'(fifo_level), 32'd1);

    // Randomized traffic with one mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        bit_valid = 1'b0;
        sync_clr  = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      step(1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
           1'($urandom_range(63) == 0),
           1'((n / 300) % 2 == 0 ? $urandom_range(3) != 0 : $urandom_range(3) == 0));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
